// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam int DIV_DEF_WIDTH = 8;
    localparam int DIV_CNT_W     = $clog2(DIV_DEF_WIDTH);

    // Bit-index counter width; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring iteration: shift in a dividend bit, subtract the divisor if it fits.
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    // One extra bit keeps the shifted-out MSB of the partial remainder.
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    assign shifted  = {rem, bit_in};
    assign diff     = shifted - {1'b0, dvs};
    assign q_bit    = (shifted >= {1'b0, dvs});
    assign rem_next = WIDTH'(q_bit ? diff : shifted);

endmodule

// File: rtl/div_restoring_param.sv
// Multi-cycle restoring divider: one quotient bit per clock, unsigned or signed (truncating).
module div_restoring_param
    import div_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] q_acc;
    logic             neg_q;
    logic             neg_r;
    logic             zero_q;

    logic             sgn;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] step_rem;
    logic             step_q;

    // The most-negative value maps to 2^(WIDTH-1), which still fits unsigned.
    assign sgn   = SIGNED_EN && is_signed;
    assign a_neg = sgn && a[WIDTH-1];
    assign b_neg = sgn && b[WIDTH-1];
    assign a_mag = a_neg ? (~a + WIDTH'(1)) : a;
    assign b_mag = b_neg ? (~b + WIDTH'(1)) : b;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .bit_in   (dvd[count]),
        .dvs      (dvs),
        .rem_next (step_rem),
        .q_bit    (step_q)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            count       <= '0;
            a_q         <= '0;
            dvd         <= '0;
            dvs         <= '0;
            rem         <= '0;
            q_acc       <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            zero_q      <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q    <= a;
                        dvd    <= a_mag;
                        dvs    <= b_mag;
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        zero_q <= (b == '0);
                        count  <= CW'(WIDTH - 1);
                        rem    <= '0;
                        q_acc  <= '0;
                        busy   <= 1'b1;
                        state  <= (b == '0) ? FIX : RUN;
                    end
                end
                RUN: begin
                    // Quotient bits arrive MSB first, so shifting left lands bit i at q[i].
                    rem   <= step_rem;
                    q_acc <= {q_acc[WIDTH-2:0], step_q};
                    if (count == '0) begin
                        state <= FIX;
                    end else begin
                        count <= count - CW'(1);
                    end
                end
                FIX: begin
                    if (zero_q) begin
                        quotient    <= '1;
                        remainder   <= a_q;
                        div_by_zero <= 1'b1;
                    end else begin
                        quotient    <= neg_q ? (~q_acc + WIDTH'(1)) : q_acc;
                        remainder   <= neg_r ? (~rem + WIDTH'(1)) : rem;
                        div_by_zero <= 1'b0;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
